// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the APB UART transmit engine.
// Holds the FSM state encoding, parity selector, length clamp and masked parity.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK,
        ST_MARK
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_ODD    = 2'b00,
        PAR_EVEN   = 2'b01,
        PAR_STICK1 = 2'b10,
        PAR_STICK0 = 2'b11
    } parity_type_e;

    localparam int MIN_CHAR_LEN = 5;
    localparam int MAX_DATA_W   = 16;

    // Out-of-range lengths saturate rather than wrap.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int maxLen);
        int l;
        logic [3:0] result;
        l = int'(len);
        result = len;
        if (l < MIN_CHAR_LEN) begin
            result = 4'(MIN_CHAR_LEN);
        end else if (l > maxLen) begin
            result = 4'(maxLen);
        end
        return result;
    endfunction

    function automatic logic masked_parity(input logic [MAX_DATA_W-1:0] data,
                                           input logic [3:0] len,
                                           input parity_type_e ptype);
        logic x;
        logic result;
        x = 1'b0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < int'(len)) begin
                x = x ^ data[i];
            end
        end
        case (ptype)
            PAR_ODD:    result = ~x;
            PAR_EVEN:   result = x;
            PAR_STICK1: result = 1'b1;
            default:    result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_engine_bit_timer.sv
// Oversample counter: counts baud ticks and flags the tick that closes a bit period.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_end
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_end = baud_tick && (cnt_q == LAST_CNT);

    // Wrap on bit_end as well so states that never change (BREAK) keep counting sanely.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (clear || bit_end) begin
            cnt_q <= '0;
        end else if (baud_tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: valid/ready character intake, LSB-first framing with optional
// parity and 1/2 stop bits, plus break generation. txd is driven straight from a flop.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              baud_tick,
    input  logic [3:0]        cfg_char_len,
    input  logic              cfg_parity_en,
    input  logic [1:0]        cfg_parity_type,
    input  logic              cfg_stop2,
    input  logic              cfg_break,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              txd
);

    tx_state_e            state_q, state_d;
    logic [DATA_W-1:0]    data_q;
    logic [3:0]           len_q;
    logic [3:0]           bitIdx_q, bitIdx_d;
    logic                 parEn_q;
    logic                 stop2_q;
    parity_type_e         parType_q;
    logic                 txd_q, txd_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 bitEnd;
    logic                 timerClear;
    logic                 parityBit;
    logic [MAX_DATA_W-1:0] dataExt;

    assign tx_ready   = (state_q == ST_IDLE) && !cfg_break;
    assign accept     = tx_valid && tx_ready;
    assign dataExt    = MAX_DATA_W'(data_q);
    assign parityBit  = masked_parity(dataExt, len_q, parType_q);
    assign timerClear = (state_q == ST_IDLE) || (state_d != state_q);

    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign txd     = txd_q;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .clear    (timerClear),
        .baud_tick(baud_tick),
        .bit_end  (bitEnd)
    );

    // Break wins over a pending character because tx_ready is already low under cfg_break.
    always_comb begin
        state_d  = state_q;
        bitIdx_d = bitIdx_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_break) begin
                    state_d = ST_BREAK;
                end else if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bitEnd) begin
                    state_d  = ST_DATA;
                    bitIdx_d = 4'd0;
                end
            end
            ST_DATA: begin
                if (bitEnd) begin
                    if (bitIdx_q == len_q - 4'd1) begin
                        state_d = parEn_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bitEnd) begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (bitEnd) begin
                    state_d = stop2_q ? ST_STOP2 : ST_IDLE;
                end
            end
            ST_STOP2: begin
                if (bitEnd) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (!cfg_break) begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK: begin
                if (bitEnd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START, ST_BREAK: txd_d = 1'b0;
            ST_DATA:            txd_d = dataExt[bitIdx_d];
            ST_PARITY:          txd_d = parityBit;
            default:            txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            bitIdx_q <= 4'd0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitIdx_q <= bitIdx_d;
            txd_q    <= txd_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_IDLE) &&
                        ((state_q == ST_STOP1) || (state_q == ST_STOP2));
        end
    end

    // Shadow copy keeps the frame in flight immune to later cfg/data changes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_q    <= '0;
            len_q     <= 4'd0;
            parEn_q   <= 1'b0;
            parType_q <= PAR_ODD;
            stop2_q   <= 1'b0;
        end else if (accept) begin
            data_q    <= tx_data;
            len_q     <= clamp_len(cfg_char_len, DATA_W);
            parEn_q   <= cfg_parity_en;
            parType_q <= parity_type_e'(cfg_parity_type);
            stop2_q   <= cfg_stop2;
        end
    end

endmodule
